// File: rtl/apb_slave_regfile.sv
// APB slave register file: parameterised width, depth, access modes and wait states.
// Optional byte-strobe support is enabled by defining APB_SLV_PSTRB_EN.
module apb_slave_regfile #(
    parameter int unsigned                DATA_WIDTH  = 32,
    parameter int unsigned                ADDR_WIDTH  = 2,
    parameter int unsigned                NUM_REGS    = 4,
    parameter logic [2*NUM_REGS-1:0]      REG_MODE    = 8'b11_00_10_01,
    parameter logic [DATA_WIDTH-1:0]      RESET_VAL   = '0,
    parameter logic [31:0]                FIXED_VAL   = 32'hDEAD_BEEF,
    parameter int unsigned                WAIT_CYCLES = 0
) (
    input  logic                           p_clk,
    input  logic                           p_rst,
    input  logic                           p_sel,
    input  logic                           p_enable,
    input  logic                           p_write,
    input  logic [ADDR_WIDTH-1:0]          p_addr,
    input  logic [DATA_WIDTH-1:0]          p_w_data,
`ifdef APB_SLV_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0]        p_strb,
`endif
    output logic                           p_ready,
    output logic                           p_slv_err,
    output logic [DATA_WIDTH-1:0]          p_r_data,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] MODE_RW    = 2'b00;
    localparam logic [1:0] MODE_RO    = 2'b01;
    localparam logic [1:0] MODE_WO    = 2'b10;
    localparam logic [1:0] MODE_FIXED = 2'b11;

    // Reject configurations the address decode and wait counter cannot support.
    if (NUM_REGS == 0 || NUM_REGS > (1 << ADDR_WIDTH) || (DATA_WIDTH % 8) != 0
        || WAIT_CYCLES > 15) begin : g_param_check
        $error("apb_slave_regfile: illegal parameter combination");
    end

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   mem_d [NUM_REGS];

    logic                    ready_c;
    logic                    err_c;
    logic                    in_range_c;
    logic [1:0]              mode_c;
    logic [DATA_WIDTH-1:0]   cur_mem_c;
    logic [DATA_WIDTH-1:0]   cur_hw_c;
    logic [DATA_WIDTH-1:0]   rd_c;
    logic [DATA_WIDTH-1:0]   wmask_c;
    logic                    strb_nz_c;

    // Byte-lane write mask and the "strobe on a read" condition.
    always_comb begin
        wmask_c   = '1;
        strb_nz_c = 1'b0;
`ifdef APB_SLV_PSTRB_EN
        for (int b = 0; b < STRB_W; b++) begin
            wmask_c[8*b +: 8] = {8{p_strb[b]}};
        end
        strb_nz_c = |p_strb;
`endif
    end

    // Decode the addressed register: range, mode, storage and status slice.
    always_comb begin
        in_range_c = 1'b0;
        mode_c     = MODE_FIXED;
        cur_mem_c  = '0;
        cur_hw_c   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (p_addr == ADDR_WIDTH'(i)) begin
                in_range_c = 1'b1;
                mode_c     = REG_MODE[2*i +: 2];
                cur_mem_c  = mem_q[i];
                cur_hw_c   = hw_status[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Completion strobe, error classification and read mux for the current access.
    always_comb begin
        ready_c = !p_rst && (state_q == S_ACCESS) && (cnt_q == CNT_W'(WAIT_CYCLES))
                  && p_sel && p_enable;
        if (!in_range_c) begin
            err_c = 1'b1;
        end else if (p_write) begin
            err_c = (mode_c == MODE_RO) || (mode_c == MODE_FIXED);
        end else begin
            err_c = (mode_c == MODE_WO) || strb_nz_c;
        end
        case (mode_c)
            MODE_RW: rd_c = cur_mem_c;
            MODE_RO: rd_c = cur_hw_c;
            MODE_WO: rd_c = '0;
            default: rd_c = DATA_WIDTH'(FIXED_VAL);
        endcase
        p_ready   = ready_c;
        p_slv_err = ready_c && err_c;
        p_r_data  = (ready_c && !err_c && !p_write) ? rd_c : '0;
    end

    // Next-state logic for the transfer FSM, wait counter and register storage.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        case (state_q)
            S_IDLE: begin
                if (p_sel && !p_enable) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                end
            end
            S_ACCESS: begin
                if (!p_sel || ready_c) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_W'(WAIT_CYCLES)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (ready_c && p_write && !err_c) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (p_addr == ADDR_WIDTH'(i)) begin
                    mem_d[i] = (mem_q[i] & ~wmask_c) | (p_w_data & wmask_c);
                end
            end
        end
    end

    // State, counter and storage registers; reset wins over any in-flight write.
    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Expose writable storage to core logic; RO and FIXED slices read as zero.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (REG_MODE[2*i +: 2] == MODE_RW || REG_MODE[2*i +: 2] == MODE_WO) begin
                reg_out[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
            end else begin
                reg_out[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    end

endmodule
